// File: rtl/memory_unit.sv
// rtl/memory_unit.sv - ASAP-1 main memory: tri-state bus port in RUN mode,
// auto-incrementing front-panel loader in PROG mode.
module memory_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int INIT_MODE  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ie,
  input  logic                  oe,
  input  logic [ADDR_WIDTH-1:0] address,
  inout  wire  [DATA_WIDTH-1:0] bus,
  input  logic                  prog_mode,
  input  logic                  prog_addr_load,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0] prog_data,
  input  logic                  prog_strobe,
  output logic [ADDR_WIDTH-1:0] prog_ptr,
  output logic [DATA_WIDTH-1:0] prog_q,
  output logic                  prog_wrapped,
  output logic                  prog_active
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {RUN = 1'b0, PROG = 1'b1} mode_t;

  mode_t                 mode_q;
  mode_t                 mode_d;
  logic                  strobe_q;
  logic                  arm_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic                  wrapped_q;

  logic                  in_prog;
  logic                  load_en;
  logic                  write_ev;
  logic                  run_we;
  logic                  we;
  logic [ADDR_WIDTH-1:0] ptr_base;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  bus_en;
  logic [DATA_WIDTH-1:0] mem_rd [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) mode_q <= RUN;
    else       mode_q <= mode_d;
  end

  always_comb begin
    mode_d   = RUN;
    in_prog  = (mode_q == PROG);
    run_we   = 1'b0;
    load_en  = 1'b0;
    write_ev = 1'b0;
    if (prog_mode) mode_d = PROG;
    if (!reset) begin
      run_we   = !in_prog && ie && !oe;
      load_en  = in_prog && prog_addr_load;
      write_ev = in_prog && prog_strobe && !strobe_q;
    end
  end

  // A load at the same edge as a write event redirects the write to prog_addr.
  assign ptr_base = load_en ? prog_addr : ptr_q;
  assign we       = run_we || write_ev;
  assign wr_addr  = run_we ? address : ptr_base;
  assign wr_data  = run_we ? bus : prog_data;

  // Reset forgets strobe history until the first PROG edge, so a strobe held
  // through reset still produces one write once PROG is reached.
  always_ff @(posedge clk) begin
    if (reset) begin
      strobe_q <= 1'b0;
      arm_q    <= 1'b1;
    end else begin
      strobe_q <= (arm_q && !in_prog) ? 1'b0 : prog_strobe;
      if (in_prog) arm_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q     <= '0;
      wrapped_q <= 1'b0;
    end else if (write_ev) begin
      ptr_q     <= ptr_base + ADDR_WIDTH'(1);
      wrapped_q <= (wrapped_q && !load_en) || (ptr_base == '1);
    end else if (load_en) begin
      ptr_q     <= prog_addr;
      wrapped_q <= 1'b0;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    logic [DATA_WIDTH-1:0] word_q = (INIT_MODE == 0) ? DATA_WIDTH'(i) : '0;
    always_ff @(posedge clk) begin
      if (we && wr_addr == ADDR_WIDTH'(i)) word_q <= wr_data;
    end
    assign mem_rd[i] = word_q;
  end

  assign bus_en       = !in_prog && oe && !reset;
  assign bus          = bus_en ? mem_rd[address] : 'z;
  assign prog_q       = mem_rd[ptr_q];
  assign prog_ptr     = ptr_q;
  assign prog_wrapped = wrapped_q;
  assign prog_active  = in_prog;

endmodule

// File: tb/tb_memory_unit.sv
// tb/tb_memory_unit.sv - directed and randomized checks of memory_unit
// against a behavioural memory/loader model.
module tb_memory_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ie = 1'b0, oe = 1'b0;
  logic [7:0] address = '0;
  logic       prog_mode = 1'b0, prog_addr_load = 1'b0, prog_strobe = 1'b0;
  logic [7:0] prog_addr = '0, prog_data = '0;
  logic [7:0] prog_ptr, prog_q;
  logic       prog_wrapped, prog_active;
  logic       tb_drv_en = 1'b0;
  logic [7:0] tb_drv = '0;
  wire  [7:0] bus;

  // Undriven bus reads as all ones so a released bus is observable.
  for (genvar b = 0; b < 8; b++) begin : g_pu
    pullup pu (bus[b]);
  end
  assign bus = tb_drv_en ? tb_drv : 'z;

  memory_unit #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .INIT_MODE(0)) dut (
    .clk(clk), .reset(reset), .ie(ie), .oe(oe), .address(address), .bus(bus),
    .prog_mode(prog_mode), .prog_addr_load(prog_addr_load), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_strobe(prog_strobe), .prog_ptr(prog_ptr),
    .prog_q(prog_q), .prog_wrapped(prog_wrapped), .prog_active(prog_active)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] mm [256];
  logic [7:0] mptr;
  logic       mwrap, mmode, mstrobe, marm;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [7:0] bv, p;
    logic       w;
    bv = tb_drv_en ? tb_drv : 8'hFF;
    if (reset) begin
      mmode = 0; mptr = 0; mwrap = 0; mstrobe = 0; marm = 1;
    end else begin
      if (!mmode && ie && !oe) mm[address] = bv;
      if (mmode) begin
        p = mptr; w = mwrap;
        if (prog_addr_load) begin p = prog_addr; w = 0; end
        if (prog_strobe && !mstrobe) begin
          mm[p] = prog_data;
          if (p == 8'hFF) w = 1;
          p = p + 8'd1;
        end
        mptr = p; mwrap = w;
      end
      mstrobe = (marm && !mmode) ? 1'b0 : prog_strobe;
      if (mmode) marm = 0;
      mmode = prog_mode;
    end
    @(posedge clk); #1;
  endtask

  task automatic check_outputs(string tag);
    logic [7:0] eb;
    if (tb_drv_en)                    eb = tb_drv;
    else if (oe && !mmode && !reset)  eb = mm[address];
    else                              eb = 8'hFF;
    chk({tag, "/bus"}, 32'(bus), 32'(eb));
    chk({tag, "/ptr"}, 32'(prog_ptr), 32'(mptr));
    chk({tag, "/q"}, 32'(prog_q), 32'(mm[mptr]));
    chk({tag, "/wrapped"}, 32'(prog_wrapped), 32'(mwrap));
    chk({tag, "/active"}, 32'(prog_active), 32'(mmode));
  endtask

  task automatic strobe_word(logic [7:0] d, int hold);
    prog_data = d; prog_strobe = 1;
    for (int k = 0; k < hold; k++) step();
    prog_strobe = 0;
    step();
  endtask

  task automatic load_ptr(logic [7:0] a);
    prog_addr = a; prog_addr_load = 1;
    step();
    prog_addr_load = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mm[i] = 8'(i);
    mptr = 0; mwrap = 0; mmode = 0; mstrobe = 0; marm = 1;

    oe = 1; address = 8'h5A;
    step(); step();
    check_outputs("reset");
    chk("reset_bus_z", 32'(bus), 32'hFF);
    reset = 0; oe = 0;
    step();

    oe = 1; address = 8'h5A; #1;
    chk("run_read_5a", 32'(bus), 32'h5A);
    check_outputs("run_read");
    oe = 0; #1;
    check_outputs("run_read_z");

    ie = 1; address = 8'h10; tb_drv_en = 1; tb_drv = 8'hC3;
    step();
    ie = 0; tb_drv_en = 0; oe = 1; #1;
    chk("run_write_c3", 32'(bus), 32'hC3);
    ie = 1;
    step();
    ie = 0; #1;
    chk("ie_oe_both", 32'(bus), 32'hC3);

    prog_mode = 1;
    step();
    chk("prog_active", 32'(prog_active), 32'h1);
    load_ptr(8'h20);
    strobe_word(8'h11, 3);
    strobe_word(8'h22, 3);
    strobe_word(8'h33, 3);
    oe = 1; address = 8'h5A; #1;
    chk("prog_ptr_23", 32'(prog_ptr), 32'h23);
    chk("prog_q_23", 32'(prog_q), 32'h23);
    check_outputs("prog_seq");
    for (int k = 0; k < 3; k++) begin
      load_ptr(8'h20 + 8'(k));
      chk("prog_words", 32'(prog_q), 32'(8'h11 * (k + 1)));
    end

    load_ptr(8'hFE);
    strobe_word(8'h5E, 1);
    strobe_word(8'h5F, 1);
    chk("wrap_ptr", 32'(prog_ptr), 32'h00);
    chk("wrap_flag", 32'(prog_wrapped), 32'h1);
    strobe_word(8'h60, 2);
    chk("wrap_sticky", 32'(prog_wrapped), 32'h1);
    load_ptr(8'h40);
    chk("wrap_clear", 32'(prog_wrapped), 32'h0);
    check_outputs("wrap");

    prog_addr = 8'h80; prog_addr_load = 1; prog_data = 8'hAA; prog_strobe = 1;
    step();
    prog_addr_load = 0; prog_strobe = 0;
    chk("simul_ptr", 32'(prog_ptr), 32'h81);
    step();
    load_ptr(8'h80);
    chk("simul_mem", 32'(prog_q), 32'hAA);

    prog_mode = 0; step();
    prog_strobe = 1; prog_data = 8'h77; step();
    prog_mode = 1; step(); step(); step();
    check_outputs("held_switch");
    chk("held_switch_mem", 32'(prog_q), 32'h80 == 32'(mptr) ? 32'hAA : 32'(mm[mptr]));
    prog_strobe = 0; step();

    load_ptr(8'hFE);
    strobe_word(8'h01, 1);
    strobe_word(8'h02, 1);
    for (int k = 0; k < 'h33; k++) strobe_word(8'($urandom), 1);
    check_outputs("pre_reset");
    prog_strobe = 1; prog_data = 8'hD4; reset = 1; oe = 1;
    step();
    check_outputs("mid_reset");
    chk("mid_reset_ptr", 32'(prog_ptr), 32'h0);
    reset = 0; oe = 0;
    step();
    step();
    chk("post_reset_ptr", 32'(prog_ptr), 32'h1);
    chk("post_reset_mem0", 32'(mm[0]), 32'hD4);
    step();
    check_outputs("post_reset");
    prog_strobe = 0; step();
    load_ptr(8'h00);
    chk("post_reset_q0", 32'(prog_q), 32'hD4);

    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 9) == 0) prog_mode = ~prog_mode;
      ie = 1'($urandom); oe = 1'($urandom);
      address = 8'($urandom);
      tb_drv_en = !oe && 1'($urandom); tb_drv = 8'($urandom);
      prog_addr_load = ($urandom_range(0, 7) == 0);
      prog_addr = 8'($urandom); prog_data = 8'($urandom);
      prog_strobe = 1'($urandom);
      #1;
      check_outputs("rnd");
      step();
    end

    reset = 0; prog_mode = 0; ie = 0; tb_drv_en = 0; prog_strobe = 0; prog_addr_load = 0;
    step(); step();
    oe = 1;
    for (int a = 0; a < 256; a++) begin
      address = 8'(a); #1;
      chk("sweep", 32'(bus), 32'(mm[a]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
